// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART tx line between NCH byte sources.
// Optional even parity bit: define UART_TX_SCHED_PARITY_EN.
module uart_tx_sched #(
  parameter int NCH       = 4,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int IDLE_GAP  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    baud_tick,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*DATA_W-1:0]   req_data,
  output logic [NCH-1:0]          req_ready,
  output logic                    tx,
  output logic                    busy,
  output logic [$clog2(NCH)-1:0]  grant_id,
  output logic                    frame_done
);
  localparam int ID_W = $clog2(NCH);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_W - 1);
  localparam logic [7:0]      STOP_LAST = 8'(STOP_BITS - 1);
  localparam logic [7:0]      GAP_LAST  = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_START, S_DATA,
`ifdef UART_TX_SCHED_PARITY_EN
    S_PARITY,
`endif
    S_STOP, S_GAP
  } state_t;

  state_t state_reg, state_next;

  logic [NCH-1:0][DATA_W-1:0] ch_data;
  logic [NCH-1:0]             above_mask, hi_req, pick_vec, pick_onehot;
  logic [NCH:0][ID_W-1:0]     sel_acc;
  logic [ID_W-1:0]            sel;
  logic                       any_valid;

  logic [ID_W-1:0]   last_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [BC_W-1:0]   bit_cnt_reg;
  logic [7:0]        slot_cnt_reg;
  logic              tx_reg;
`ifdef UART_TX_SCHED_PARITY_EN
  logic              parity_reg;
`endif

  // Channels above the last winner take priority; if none, wrap to the lowest index.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_data[gi]    = req_data[gi*DATA_W +: DATA_W];
      assign above_mask[gi] = (ID_W'(gi) > last_reg);
      assign sel_acc[gi+1]  = sel_acc[gi] | (pick_onehot[gi] ? ID_W'(gi) : '0);
    end
  endgenerate

  assign sel_acc[0]  = '0;
  assign any_valid   = |req_valid;
  assign hi_req      = req_valid & above_mask;
  assign pick_vec    = (|hi_req) ? hi_req : req_valid;
  assign pick_onehot = pick_vec & (~pick_vec + NCH'(1));
  assign sel         = sel_acc[NCH];
  assign tx          = tx_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (any_valid) state_next = S_ALIGN;
      S_ALIGN:  if (baud_tick) state_next = S_START;
      S_START:  if (baud_tick) state_next = S_DATA;
      S_DATA:
        if (baud_tick && bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_SCHED_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
`ifdef UART_TX_SCHED_PARITY_EN
      S_PARITY: if (baud_tick) state_next = S_STOP;
`endif
      S_STOP:
        if (baud_tick && slot_cnt_reg == STOP_LAST)
          state_next = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:    if (baud_tick && slot_cnt_reg == GAP_LAST) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    frame_done = 1'b0;
    busy       = (state_reg != S_IDLE);
    if (!reset) begin
      if (state_reg == S_IDLE && any_valid) req_ready = pick_onehot;
      if (state_reg != S_IDLE && state_next == S_IDLE) frame_done = 1'b1;
    end
  end

  // Serializer datapath; tx changes only on baud ticks once a frame is under way.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_reg       <= 1'b1;
      grant_id     <= '0;
      last_reg     <= ID_W'(NCH - 1);
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      slot_cnt_reg <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE:
          if (any_valid) begin
            shift_reg <= ch_data[sel];
            grant_id  <= sel;
            last_reg  <= sel;
`ifdef UART_TX_SCHED_PARITY_EN
            parity_reg <= ^ch_data[sel];
`endif
          end
        S_ALIGN:
          if (baud_tick) tx_reg <= 1'b0;
        S_START:
          if (baud_tick) begin
            tx_reg      <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= '0;
          end
        S_DATA:
          if (baud_tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_SCHED_PARITY_EN
              tx_reg <= parity_reg;
`else
              tx_reg <= 1'b1;
`endif
              slot_cnt_reg <= '0;
            end else begin
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
            end
          end
`ifdef UART_TX_SCHED_PARITY_EN
        S_PARITY:
          if (baud_tick) begin
            tx_reg       <= 1'b1;
            slot_cnt_reg <= '0;
          end
`endif
        S_STOP:
          if (baud_tick)
            slot_cnt_reg <= (slot_cnt_reg == STOP_LAST) ? 8'd0 : slot_cnt_reg + 8'd1;
        S_GAP:
          if (baud_tick) slot_cnt_reg <= slot_cnt_reg + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two configurations driven in parallel, each checked
// every cycle against a frame-queue reference model.
module tb_uart_tx_sched;
  localparam int NCH = 4, DATA_W = 8, BAUD = 16;
  localparam int STOP_A = 1, GAP_A = 0, STOP_B = 2, GAP_B = 2;

  logic clk = 1'b0, reset = 1'b1, baud_tick = 1'b0;
  logic [NCH-1:0]        req_valid = '0;
  logic [NCH*DATA_W-1:0] req_data = '0;
  logic [NCH-1:0] ready_a, ready_b;
  logic tx_a, tx_b, busy_a, busy_b, fd_a, fd_b;
  logic [1:0] gid_a, gid_b;

  int checks = 0, errors = 0;
  int tick_mode = 0, tick_cnt = 0;
  logic chk_en = 1'b0;

  // Reference model: per configuration, the list of per-baud-period tx levels still to send.
  logic        m_active [2];
  logic        m_tx     [2];
  int          m_ptr    [2];
  int          m_grant  [2];
  logic [31:0] m_bits   [2];
  int          m_left   [2];

  always #5 clk = ~clk;

  uart_tx_sched #(.NCH(NCH), .DATA_W(DATA_W), .STOP_BITS(STOP_A), .IDLE_GAP(GAP_A)) u_dut_a (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .req_valid(req_valid),
    .req_data(req_data), .req_ready(ready_a), .tx(tx_a), .busy(busy_a),
    .grant_id(gid_a), .frame_done(fd_a));

  uart_tx_sched #(.NCH(NCH), .DATA_W(DATA_W), .STOP_BITS(STOP_B), .IDLE_GAP(GAP_B)) u_dut_b (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .req_valid(req_valid),
    .req_data(req_data), .req_ready(ready_b), .tx(tx_b), .busy(busy_b),
    .grant_id(gid_b), .frame_done(fd_b));

  function automatic int rr_pick(int ptr, logic [NCH-1:0] v);
    logic [NCH-1:0] t;
    for (int k = 1; k <= NCH; k++) begin
      t = v >> ((ptr + k) % NCH);
      if (t[0]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  function automatic void build_frame(logic d, logic [DATA_W-1:0] data);
    logic [31:0]       b  = '0;
    logic [DATA_W-1:0] dv = data;
    int n = 1;
    int tail = d ? (STOP_B + GAP_B) : (STOP_A + GAP_A);
    for (int i = 0; i < DATA_W; i++) begin
      b = b | (32'(dv[0]) << n);
      dv = dv >> 1;
      n++;
    end
`ifdef UART_TX_SCHED_PARITY_EN
    b = b | (32'(^data) << n);
    n++;
`endif
    for (int i = 0; i < tail; i++) begin
      b = b | (32'd1 << n);
      n++;
    end
    m_bits[d] = b;
    m_left[d] = n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(logic d);
    logic [NCH-1:0] exp_ready;
    logic           exp_fd;
    string          nm;
    nm = d ? "B" : "A";
    exp_ready = '0;
    if (!reset && !m_active[d] && (|req_valid))
      exp_ready = NCH'(1) << rr_pick(m_ptr[d], req_valid);
    exp_fd = !reset && m_active[d] && baud_tick && (m_left[d] == 0);
    chk({nm, ".tx"},         32'(d ? tx_b : tx_a),       32'(m_tx[d]));
    chk({nm, ".busy"},       32'(d ? busy_b : busy_a),   32'(m_active[d]));
    chk({nm, ".req_ready"},  32'(d ? ready_b : ready_a), 32'(exp_ready));
    chk({nm, ".frame_done"}, 32'(d ? fd_b : fd_a),       32'(exp_fd));
    chk({nm, ".grant_id"},   32'(d ? gid_b : gid_a),     32'(m_grant[d]));
  endtask

  task automatic update_dut(logic d);
    int p;
    logic [NCH*DATA_W-1:0] t;
    if (reset) begin
      m_active[d] = 1'b0;
      m_tx[d]     = 1'b1;
      m_ptr[d]    = NCH - 1;
      m_grant[d]  = 0;
      m_left[d]   = 0;
    end else if (m_active[d]) begin
      if (baud_tick) begin
        if (m_left[d] == 0) m_active[d] = 1'b0;
        else begin
          m_tx[d]   = m_bits[d][0];
          m_bits[d] = m_bits[d] >> 1;
          m_left[d]--;
        end
      end
    end else if (|req_valid) begin
      p = rr_pick(m_ptr[d], req_valid);
      t = req_data >> (p * DATA_W);
      m_grant[d]  = p;
      m_ptr[d]    = p;
      m_active[d] = 1'b1;
      build_frame(d, t[DATA_W-1:0]);
      $display("[%0t] dut %s accept ch%0d data %02h", $time, d ? "B" : "A", p, t[DATA_W-1:0]);
    end
  endtask

  // One clock: inputs already stable from just after the previous rising edge.
  task automatic step();
    if (tick_mode == 0) begin
      baud_tick = (tick_cnt == BAUD - 1);
      tick_cnt  = (tick_cnt + 1) % BAUD;
    end else begin
      baud_tick = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    if (chk_en) begin
      check_dut(1'b0);
      check_dut(1'b1);
    end
    update_dut(1'b0);
    update_dut(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset = 1'b1;
    run(2);
    reset  = 1'b0;
    chk_en = 1'b1;
    run(3);

    // Single request from ch2 with 0xA5.
    req_data  = {4{8'hA5}};
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    run(260);

    // All channels continuously valid; data churns mid-frame.
    req_valid = '1;
    for (int i = 0; i < 1300; i++) begin
      if (i % 7 == 0) req_data = {$urandom, $urandom} >> 0;
      step();
    end
    req_valid = '0;
    run(260);

    // Accept lands in the same cycle as a baud tick.
    while (tick_cnt != BAUD - 1) step();
    req_data  = {8'h3C, 8'h00, 8'h00, 8'h00};
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    run(260);

    // Reset in the middle of ch1's data bits, then ch1/ch3 compete.
    req_data  = {8'h11, 8'h22, 8'h5A, 8'h44};
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    run(BAUD * 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 4'b1010;
    step();
    req_valid = '0;
    run(260);

    // Parity-sensitive bytes (odd and even population counts).
    req_data  = 32'h0000_0007;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    run(260);
    req_data  = 32'h0000_0003;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    run(260);

    // Randomized segments: random valids/data, irregular ticks, occasional reset.
    for (int s = 0; s < 60; s++) begin
      tick_mode = $urandom_range(0, 1);
      req_valid = NCH'($urandom);
      req_data  = {$urandom, $urandom} >> 0;
      reset     = ($urandom_range(0, 14) == 0);
      step();
      reset = 1'b0;
      run($urandom_range(5, 80));
    end
    tick_mode = 0;
    req_valid = '0;
    run(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
